usb_tx_frame_arbiter: RTL



---
 rtl/usb_tx_frame_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_frame_arbiter.sv
// usb_tx_frame_arbiter
// Shares the single USB tx-FIFO write port between NCH requesters. Whole packets
// are granted in round-robin order and each is wrapped in a frame:
//   SYNC, channel id, length, payload[len], XOR checksum (id ^ len ^ payload).
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   ch_req       per-channel packet pending (level, held until ch_done)
//   ch_len       per-channel payload length, 8 bits per channel
//   ch_data      per-channel payload byte, 8 bits per channel
//   ch_valid     per-channel payload byte valid
//   ch_ready     per-channel payload byte accepted this cycle (combinational)
//   ch_done      one-cycle pulse once the channel's checksum byte is issued
//   fifo_valid   registered write strobe to the tx FIFO
//   fifo_din     registered byte to the tx FIFO
//   fifo_usedw   tx FIFO fill level (WUSEDW+1 bits)
//   fifo_full    tx FIFO full; holds the frame without issuing a byte
//   grant        currently granted channel, valid while busy
//   busy         a frame is in progress
module usb_tx_frame_arbiter #(
    parameter int          NCH    = 4,
    parameter int          WUSEDW = 17,
    parameter logic [7:0]  SYNC   = 8'hA5,
    localparam int         GW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_req,
    input  logic [8*NCH-1:0]  ch_len,
    input  logic [8*NCH-1:0]  ch_data,
    input  logic [NCH-1:0]    ch_valid,
    output logic [NCH-1:0]    ch_ready,
    output logic [NCH-1:0]    ch_done,
    output logic              fifo_valid,
    output logic [7:0]        fifo_din,
    input  logic [WUSEDW:0]   fifo_usedw,
    input  logic              fifo_full,
    output logic [GW-1:0]     grant,
    output logic              busy
);

    // Wide enough for capacity, fill level and len+4 without wrapping.
    localparam int CW = (WUSEDW + 2 > 10) ? WUSEDW + 2 : 10;

    typedef enum logic [2:0] {
        StIdle, StSync, StId, StLen, StPayload, StCsum, StDone
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  rr_q, rr_d;
    logic           busy_q, busy_d;
    logic [7:0]     len_cnt_q, len_cnt_d;
    logic [7:0]     csum_q, csum_d;
    logic           fifo_valid_q, fifo_valid_d;
    logic [7:0]     fifo_din_q, fifo_din_d;
    logic [NCH-1:0] ch_done_q, ch_done_d;

    logic           cand_found;
    logic [GW-1:0]  cand;
    logic [7:0]     cand_len;
    logic [CW-1:0]  cap, used, free, need;
    logic           space_ok;
    logic [7:0]     id_byte;
    logic [7:0]     g_data;
    logic           g_valid;
    int unsigned    idx;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        idx        = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(rr_q) + k) % NCH;
            if (!cand_found && ch_req[idx]) begin
                cand_found = 1'b1;
                cand       = GW'(idx);
            end
        end
    end

    // Only the candidate is space-checked; a short FIFO stalls rather than
    // skipping ahead, so a long packet can never be starved by short ones.
    always_comb begin
        cand_len = ch_len[8*int'(cand) +: 8];
        cap      = CW'(1) << WUSEDW;
        used     = CW'(fifo_usedw);
        free     = (used > cap) ? '0 : cap - used;
        need     = CW'(cand_len) + CW'(4);
        space_ok = (free >= need);
    end

    assign id_byte = 8'(grant_q);
    assign g_data  = ch_data[8*int'(grant_q) +: 8];
    assign g_valid = ch_valid[grant_q];

    always_comb begin
        ch_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_ready[i] = busy_q && (grant_q == GW'(i)) && (state_q == StPayload) && !fifo_full;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        busy_d       = busy_q;
        len_cnt_d    = len_cnt_q;
        csum_d       = csum_q;
        fifo_valid_d = 1'b0;
        fifo_din_d   = fifo_din_q;
        ch_done_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (cand_found && space_ok) begin
                    grant_d   = cand;
                    len_cnt_d = cand_len;
                    rr_d      = cand;
                    busy_d    = 1'b1;
                    csum_d    = 8'h00;
                    state_d   = StSync;
                end
            end
            StSync: begin
                if (!fifo_full) begin
                    fifo_valid_d = 1'b1;
                    fifo_din_d   = SYNC;
                    state_d      = StId;
                end
            end
            StId: begin
                if (!fifo_full) begin
                    fifo_valid_d = 1'b1;
                    fifo_din_d   = id_byte;
                    csum_d       = csum_q ^ id_byte;
                    state_d      = StLen;
                end
            end
            StLen: begin
                if (!fifo_full) begin
                    fifo_valid_d = 1'b1;
                    fifo_din_d   = len_cnt_q;
                    csum_d       = csum_q ^ len_cnt_q;
                    state_d      = (len_cnt_q == 8'd0) ? StCsum : StPayload;
                end
            end
            StPayload: begin
                if (g_valid && !fifo_full) begin
                    fifo_valid_d = 1'b1;
                    fifo_din_d   = g_data;
                    csum_d       = csum_q ^ g_data;
                    len_cnt_d    = len_cnt_q - 8'd1;
                    if (len_cnt_q == 8'd1) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (!fifo_full) begin
                    fifo_valid_d       = 1'b1;
                    fifo_din_d         = csum_q;
                    ch_done_d[grant_q] = 1'b1;
                    state_d            = StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_q         <= GW'(NCH - 1);
            busy_q       <= 1'b0;
            len_cnt_q    <= 8'd0;
            csum_q       <= 8'd0;
            fifo_valid_q <= 1'b0;
            fifo_din_q   <= 8'd0;
            ch_done_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            busy_q       <= busy_d;
            len_cnt_q    <= len_cnt_d;
            csum_q       <= csum_d;
            fifo_valid_q <= fifo_valid_d;
            fifo_din_q   <= fifo_din_d;
            ch_done_q    <= ch_done_d;
        end
    end

    assign fifo_valid = fifo_valid_q;
    assign fifo_din   = fifo_din_q;
    assign ch_done    = ch_done_q;
    assign grant      = grant_q;
    assign busy       = busy_q;

endmodule
